// File: rtl/grad_set_assoc_buffer.sv
// Set-associative gradient accumulation buffer with a single registered writeback stream.
// Optional statistics counters are enabled by defining GRAD_BUF_STATS_EN.
module grad_set_assoc_buffer #(
  parameter int unsigned        DEPTH     = 256,
  parameter int unsigned        NUM_WAYS  = 4,
  parameter logic signed [31:0] THRESHOLD = 32'sd1000,
  localparam int unsigned       NUM_SETS  = DEPTH / NUM_WAYS,
  localparam int unsigned       SW        = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_addr,
  input  logic [SW-1:0] in_set_index,
  input  logic [31:0]   in_grad_ext,
  input  logic          in_direct_trigger,
  input  logic          flush_req,
  output logic          flush_done,
  output logic          wb_valid,
  input  logic          wb_ready,
  output logic [31:0]   wb_addr,
`ifdef GRAD_BUF_STATS_EN
  output logic [31:0]   stat_hits,
  output logic [31:0]   stat_evicts,
  output logic [31:0]   stat_thresh,
`endif
  output logic [31:0]   wb_value
);

  localparam int unsigned WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int unsigned IW = $clog2(DEPTH);

  // Two's-complement magnitude widened so that -2^31 is representable.
  function automatic logic [32:0] mag33(input logic [31:0] v);
    logic [32:0] e;
    e = {v[31], v};
    return v[31] ? (~e + 33'd1) : e;
  endfunction

  localparam logic [32:0] THR_MAG = mag33(THRESHOLD);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [31:0]       tag_q   [DEPTH];
  logic [31:0]       tag_d   [DEPTH];
  logic [31:0]       acc_q   [DEPTH];
  logic [31:0]       acc_d   [DEPTH];
  logic [WW-1:0]     ptr_q   [NUM_SETS];
  logic [WW-1:0]     ptr_d   [NUM_SETS];
  logic [IW-1:0]     scan_q, scan_d;
  logic              scan_done_q, scan_done_d;
  logic              wb_valid_q, wb_valid_d;
  logic [31:0]       wb_addr_q, wb_addr_d;
  logic [31:0]       wb_value_q, wb_value_d;
  logic              flush_done_q, flush_done_d;

  logic              accept, wb_free, hit, has_free, over;
  logic [IW-1:0]     hit_idx, free_idx, victim_idx;
  logic [32:0]       sum_wide;
  logic [31:0]       sum_sat;

  assign wb_free  = ~wb_valid_q | wb_ready;
  assign in_ready = (state_q == StRun) & ~flush_req & wb_free;
  assign accept   = in_valid & in_ready;

  // Set lookup: hit way, lowest free way and round-robin victim.
  always_comb begin
    hit      = 1'b0;
    has_free = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    // Descending scan so the lowest matching way wins.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[{in_set_index, WW'(w)}]) begin
        has_free = 1'b1;
        free_idx = {in_set_index, WW'(w)};
      end
      if (valid_q[{in_set_index, WW'(w)}] && tag_q[{in_set_index, WW'(w)}] == in_addr) begin
        hit     = 1'b1;
        hit_idx = {in_set_index, WW'(w)};
      end
    end
    victim_idx = {in_set_index, ptr_q[in_set_index]};
  end

  // Saturating accumulate and threshold comparison on magnitudes.
  always_comb begin
    sum_wide = {acc_q[hit_idx][31], acc_q[hit_idx]} + {in_grad_ext[31], in_grad_ext};
    if (sum_wide[32] != sum_wide[31]) begin
      sum_sat = sum_wide[32] ? 32'h8000_0000 : 32'h7fff_ffff;
    end else begin
      sum_sat = sum_wide[31:0];
    end
    over = mag33(sum_sat) >= THR_MAG;
  end

  // Next-state: request rules in RUN, sequential drain in FLUSH.
  always_comb begin
    state_d      = state_q;
    scan_d       = scan_q;
    scan_done_d  = scan_done_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    acc_d        = acc_q;
    ptr_d        = ptr_q;
    wb_valid_d   = wb_valid_q & ~wb_ready;
    wb_addr_d    = wb_addr_q;
    wb_value_d   = wb_value_q;
    flush_done_d = 1'b0;
    case (state_q)
      StRun: begin
        if (flush_req) begin
          state_d     = StFlush;
          scan_d      = '0;
          scan_done_d = 1'b0;
        end else if (accept) begin
          if (in_direct_trigger) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = in_addr;
            wb_value_d = hit ? sum_sat : in_grad_ext;
            if (hit) valid_d[hit_idx] = 1'b0;
          end else if (hit) begin
            if (over) begin
              wb_valid_d       = 1'b1;
              wb_addr_d        = in_addr;
              wb_value_d       = sum_sat;
              valid_d[hit_idx] = 1'b0;
            end else begin
              acc_d[hit_idx] = sum_sat;
            end
          end else if (has_free) begin
            valid_d[free_idx] = 1'b1;
            tag_d[free_idx]   = in_addr;
            acc_d[free_idx]   = in_grad_ext;
          end else begin
            wb_valid_d              = 1'b1;
            wb_addr_d               = tag_q[victim_idx];
            wb_value_d              = acc_q[victim_idx];
            tag_d[victim_idx]       = in_addr;
            acc_d[victim_idx]       = in_grad_ext;
            ptr_d[in_set_index]     = ptr_q[in_set_index] + WW'(1);
          end
        end
      end
      default: begin
        if (!scan_done_q) begin
          // Valid entries stall the scan until the output register frees up.
          if (!valid_q[scan_q] || wb_free) begin
            if (valid_q[scan_q]) begin
              wb_valid_d      = 1'b1;
              wb_addr_d       = tag_q[scan_q];
              wb_value_d      = acc_q[scan_q];
              valid_d[scan_q] = 1'b0;
            end
            if (scan_q == IW'(DEPTH - 1)) begin
              scan_done_d = 1'b1;
            end else begin
              scan_d = scan_q + IW'(1);
            end
          end
        end else if (wb_free) begin
          flush_done_d = 1'b1;
          state_d      = StRun;
        end
      end
    endcase
  end

  // Control state with synchronous reset; buffered sums are dropped via valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      scan_q       <= '0;
      scan_done_q  <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_value_q   <= '0;
      flush_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) ptr_q[s] <= '0;
    end else begin
      state_q      <= state_d;
      scan_q       <= scan_d;
      scan_done_q  <= scan_done_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_value_q   <= wb_value_d;
      flush_done_q <= flush_done_d;
      valid_q      <= valid_d;
      ptr_q        <= ptr_d;
    end
  end

  // Entry payload storage; contents are meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    acc_q <= acc_d;
  end

  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign wb_value   = wb_value_q;
  assign flush_done = flush_done_q;

`ifdef GRAD_BUF_STATS_EN
  logic [31:0] stat_hits_q, stat_evicts_q, stat_thresh_q;

  // Event counters sampled on accepted requests; they wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits_q   <= '0;
      stat_evicts_q <= '0;
      stat_thresh_q <= '0;
    end else begin
      if (accept && hit) stat_hits_q <= stat_hits_q + 32'd1;
      if (accept && !in_direct_trigger && !hit && !has_free) begin
        stat_evicts_q <= stat_evicts_q + 32'd1;
      end
      if (accept && (in_direct_trigger || (hit && over))) begin
        stat_thresh_q <= stat_thresh_q + 32'd1;
      end
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_evicts = stat_evicts_q;
  assign stat_thresh = stat_thresh_q;
`endif

endmodule

// File: tb/tb_grad_set_assoc_buffer.sv
// Randomized bench for grad_set_assoc_buffer (DEPTH=16, NUM_WAYS=4, THRESHOLD=1000) with a
// behavioural reference model and an expected-writeback queue.
module tb_grad_set_assoc_buffer;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_direct_trigger, flush_req, flush_done;
  logic        wb_valid, wb_ready;
  logic [31:0] in_addr, in_grad_ext, wb_addr, wb_value;
  logic [1:0]  in_set_index;
`ifdef GRAD_BUF_STATS_EN
  logic [31:0] stat_hits, stat_evicts, stat_thresh;
`endif

  always #5 clk = ~clk;

  grad_set_assoc_buffer #(
    .DEPTH     (16),
    .NUM_WAYS  (4),
    .THRESHOLD (32'sd1000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_addr           (in_addr),
    .in_set_index      (in_set_index),
    .in_grad_ext       (in_grad_ext),
    .in_direct_trigger (in_direct_trigger),
    .flush_req         (flush_req),
    .flush_done        (flush_done),
    .wb_valid          (wb_valid),
    .wb_ready          (wb_ready),
    .wb_addr           (wb_addr),
`ifdef GRAD_BUF_STATS_EN
    .stat_hits         (stat_hits),
    .stat_evicts       (stat_evicts),
    .stat_thresh       (stat_thresh),
`endif
    .wb_value          (wb_value)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] value;
  } wb_t;

  wb_t         exp_q[$];
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  int          m_acc   [16];
  int          m_ptr   [4];
  int unsigned m_hits, m_evicts, m_thresh;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat32(input longint s);
    if (s > 64'sd2147483647) return 2147483647;
    if (s < -64'sd2147483648) return int'(32'h8000_0000);
    return int'(s);
  endfunction

  function automatic longint absl(input longint x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    for (int s = 0; s < 4; s++) m_ptr[s] = 0;
    exp_q.delete();
    m_hits = 0; m_evicts = 0; m_thresh = 0;
  endtask

  task automatic emit(input logic [31:0] a, input int v);
    wb_t e;
    e.addr = a;
    e.value = v;
    exp_q.push_back(e);
  endtask

  // Reference behaviour of one accepted request.
  task automatic model_accept(input logic [31:0] a, input int g, input bit d);
    int set, h, fr;
    int s;
    set = int'(a[1:0]);
    h = -1;
    fr = -1;
    for (int w = 3; w >= 0; w--) begin
      if (m_valid[set*4+w] && m_tag[set*4+w] == a) h = set*4 + w;
      if (!m_valid[set*4+w]) fr = set*4 + w;
    end
    s = (h >= 0) ? sat32(longint'(m_acc[h]) + longint'(g)) : 0;
    if (d) begin
      m_thresh++;
      if (h >= 0) begin
        m_hits++;
        emit(a, s);
        m_valid[h] = 1'b0;
      end else begin
        emit(a, g);
      end
    end else if (h >= 0) begin
      m_hits++;
      if (absl(longint'(s)) >= 1000) begin
        m_thresh++;
        emit(a, s);
        m_valid[h] = 1'b0;
      end else begin
        m_acc[h] = s;
      end
    end else if (fr >= 0) begin
      m_valid[fr] = 1'b1;
      m_tag[fr] = a;
      m_acc[fr] = g;
    end else begin
      m_evicts++;
      emit(m_tag[set*4+m_ptr[set]], m_acc[set*4+m_ptr[set]]);
      m_tag[set*4+m_ptr[set]] = a;
      m_acc[set*4+m_ptr[set]] = g;
      m_ptr[set] = (m_ptr[set] + 1) % 4;
    end
  endtask

  // Called at a post-edge sample point right after the flush request was taken.
  task automatic do_flush();
    bit done = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (m_valid[i]) emit(m_tag[i], m_acc[i]);
      m_valid[i] = 1'b0;
    end
    for (int c = 0; c < 200; c++) begin
      if (flush_done) begin
        done = 1'b1;
        break;
      end
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          check("flush_extra_wb", wb_valid, 1'b0);
        end else begin
          check("flush_wb_addr", wb_addr, exp_q[0].addr);
          check("flush_wb_value", wb_value, exp_q[0].value);
        end
      end
      in_valid = $urandom_range(0, 1);
      flush_req = ($urandom_range(0, 3) == 0);
      wb_ready = ($urandom_range(0, 3) != 0);
      #1;
      check("flush_in_ready", in_ready, 1'b0);
      if (wb_valid && wb_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      @(posedge clk);
      #1;
    end
    check("flush_done_seen", done, 1'b1);
    check("flush_drained", exp_q.size(), 0);
    check("flush_wb_idle", wb_valid, 1'b0);
    exp_q.delete();
    in_valid = 1'b0;
    flush_req = 1'b0;
    wb_ready = 1'b1;
    #1;
    check("post_flush_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    check("flush_done_pulse", flush_done, 1'b0);
  endtask

  // One RUN-state cycle, entered and left at a post-edge sample point.
  task automatic run_cycle(input bit v, input logic [31:0] a, input int g, input bit d,
                           input bit r, input bit f);
    bit exp_rdy;
    check("wb_valid", wb_valid, exp_q.size() != 0);
    check("flush_done_idle", flush_done, 1'b0);
    if (wb_valid && exp_q.size() != 0) begin
      check("wb_addr", wb_addr, exp_q[0].addr);
      check("wb_value", wb_value, exp_q[0].value);
    end
    in_valid = v;
    in_addr = a;
    in_set_index = a[1:0];
    in_grad_ext = g;
    in_direct_trigger = d;
    wb_ready = r;
    flush_req = f;
    #1;
    exp_rdy = !f && (exp_q.size() == 0 || r);
    check("in_ready", in_ready, exp_rdy);
    if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
    if (v && exp_rdy) model_accept(a, g, d);
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    if (f) do_flush();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 32'h0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int g;
    rst = 1'b1;
    in_valid = 1'b0;
    in_addr = '0;
    in_set_index = '0;
    in_grad_ext = '0;
    in_direct_trigger = 1'b0;
    flush_req = 1'b0;
    wb_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_addr", wb_addr, 32'h0);
    check("rst_wb_value", wb_value, 32'h0);
    check("rst_flush_done", flush_done, 1'b0);

    // Accumulate to threshold.
    run_cycle(1, 32'h5, 400, 0, 1, 0);
    run_cycle(1, 32'h5, 400, 0, 1, 0);
    run_cycle(1, 32'h5, 300, 0, 1, 0);
    idle(2);
    // Direct trigger on a hit, then a miss on the freed address.
    run_cycle(1, 32'h1, 200, 0, 1, 0);
    run_cycle(1, 32'h1, -1500, 1, 1, 0);
    idle(1);
    run_cycle(1, 32'h1, 7, 0, 1, 0);
    idle(2);
    // Round-robin eviction in set 0.
    run_cycle(1, 32'h0, 10, 0, 1, 0);
    run_cycle(1, 32'h4, 10, 0, 1, 0);
    run_cycle(1, 32'h8, 10, 0, 1, 0);
    run_cycle(1, 32'hC, 10, 0, 1, 0);
    run_cycle(1, 32'h10, 20, 0, 1, 0);
    idle(1);
    run_cycle(1, 32'h14, 5, 0, 1, 0);
    idle(1);
    // Backpressure holds the writeback and blocks requests.
    run_cycle(1, 32'h9, 2000, 1, 1, 0);
    for (int i = 0; i < 5; i++) run_cycle(1, 32'h6, 3, 0, 0, 0);
    run_cycle(0, 32'h0, 0, 0, 1, 0);
    idle(1);
    // Empty the buffer, then the flush scenario with a later miss.
    run_cycle(0, 32'h0, 0, 0, 1, 1);
    run_cycle(1, 32'h2, 50, 0, 1, 0);
    run_cycle(1, 32'h3, -60, 0, 1, 0);
    run_cycle(0, 32'h0, 0, 0, 1, 1);
    run_cycle(1, 32'h2, 5, 0, 1, 0);
    idle(2);
    // Saturating sum on a direct hit.
    run_cycle(1, 32'h7, -500, 0, 1, 0);
    run_cycle(1, 32'h7, int'(32'h8000_0000), 1, 1, 0);
    idle(1);

    // Randomized traffic with occasional flushes and backpressure.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0:       g = $urandom_range(0, 1) ? 2147483647 : int'(32'h8000_0000);
        1, 2:    g = int'($urandom_range(0, 3000)) - 1500;
        default: g = int'($urandom_range(0, 1200)) - 600;
      endcase
      run_cycle($urandom_range(0, 3) != 0, 32'($urandom_range(0, 31)), g,
                absl(longint'(g)) >= 1000, $urandom_range(0, 3) != 0,
                $urandom_range(0, 119) == 0);
    end
    idle(2);

    // Reset in the middle of a stalled flush.
    run_cycle(1, 32'h2, 50, 0, 1, 0);
    run_cycle(1, 32'h3, -60, 0, 1, 0);
    idle(1);
    in_valid = 1'b0;
    flush_req = 1'b1;
    wb_ready = 1'b0;
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("rmf_wb_pending", wb_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("rmf_wb_valid", wb_valid, 1'b0);
    check("rmf_flush_done", flush_done, 1'b0);
    check("rmf_in_ready", in_ready, 1'b1);
    idle(20);
    run_cycle(1, 32'h3, 5, 0, 1, 0);
    idle(2);

`ifdef GRAD_BUF_STATS_EN
    check("stat_hits", stat_hits, m_hits);
    check("stat_evicts", stat_evicts, m_evicts);
    check("stat_thresh", stat_thresh, m_thresh);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
